card_dealer: RTL

- Sequential card source that deals two distinct poker hands from one 52-card deck, one card per valid/ready handshake.
- Cards alternate between player 0 and player 1.
- Sits upstream of the per-player hand-evaluation and winner-comparison logic.
- Rank and player encodings match that logic: rank 2..14 with ace = 14; player 0/1 matches the winner output.

---
 rtl/card_dealer_if.sv | 28 ++
 rtl/card_dealer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/card_dealer_if.sv
// Card stream between the dealer and the hand-evaluation consumers.
// The dealer holds every card field stable while card_valid is high and card_ready is low.
interface card_dealer_if;
  logic       card_valid;
  logic       card_ready;
  logic [3:0] card_rank;
  logic [1:0] card_suit;
  logic       card_player;
  logic [2:0] card_slot;

  modport master (
    output card_valid,
    output card_rank,
    output card_suit,
    output card_player,
    output card_slot,
    input  card_ready
  );

  modport slave (
    input  card_valid,
    input  card_rank,
    input  card_suit,
    input  card_player,
    input  card_slot,
    output card_ready
  );
endinterface

// File: rtl/card_dealer.sv
// Deals two distinct poker hands from one 52-card deck, one card per valid/ready handshake.
// Cards alternate player 0 / player 1; deck positions come from a 16-bit Galois LFSR
// with linear probing over a used-card mask.
//
//   state   | meaning
//   --------+--------------------------------------------------
//   IDLE    | waiting for start; seed_load accepted here only
//   PICK    | advance LFSR, reduce its low 6 bits to a deck index
//   PROBE   | take the index if unused, else step to the next one
//   PRESENT | card_valid high, card held until accepted
//   DONE    | one-cycle done pulse, then back to IDLE
module card_dealer #(
  parameter int          CARDS_PER_PLAYER = 5,
  parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          seed_load,
  input  logic [15:0]   seed,
  output logic          busy,
  output logic          done,
  card_dealer_if.master cards
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PICK    = 3'd1,
    PROBE   = 3'd2,
    PRESENT = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [3:0]  LAST_CARD = 4'(2 * CARDS_PER_PLAYER - 1);
  localparam logic [15:0] TAPS      = 16'hB400;
  localparam logic [5:0]  DECK_LAST = 6'd51;
  localparam logic [5:0]  DECK_SIZE = 6'd52;

  state_t      state, state_nxt;
  logic [15:0] lfsr, lfsr_nxt, lfsr_adv;
  logic [51:0] used, used_nxt;
  logic [3:0]  count, count_nxt;
  logic [5:0]  idx, idx_nxt, idx_raw;
  logic [3:0]  rank, rank_nxt;
  logic [1:0]  suit, suit_nxt;
  logic        player, player_nxt;
  logic [2:0]  slot, slot_nxt;

  logic [1:0]  suit_of_idx;
  logic [5:0]  suit_base;
  logic [3:0]  rank_of_idx;

  always_comb begin
    lfsr_adv = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);
    idx_raw  = (lfsr_adv[5:0] >= DECK_SIZE) ? (lfsr_adv[5:0] - DECK_SIZE) : lfsr_adv[5:0];
  end

  // idx / 13 and idx % 13 by range compare; the deck index never exceeds 51
  always_comb begin
    if (idx >= 6'd39) begin
      suit_of_idx = 2'd3;
      suit_base   = 6'd39;
    end else if (idx >= 6'd26) begin
      suit_of_idx = 2'd2;
      suit_base   = 6'd26;
    end else if (idx >= 6'd13) begin
      suit_of_idx = 2'd1;
      suit_base   = 6'd13;
    end else begin
      suit_of_idx = 2'd0;
      suit_base   = 6'd0;
    end
    rank_of_idx = 4'(idx - suit_base + 6'd2);
  end

  always_comb begin
    state_nxt  = state;
    lfsr_nxt   = lfsr;
    used_nxt   = used;
    count_nxt  = count;
    idx_nxt    = idx;
    rank_nxt   = rank;
    suit_nxt   = suit;
    player_nxt = player;
    slot_nxt   = slot;
    unique case (state)
      IDLE: begin
        // seed lands before the first PICK, so a same-cycle start deals from it
        if (seed_load)
          lfsr_nxt = (seed == 16'h0000) ? LFSR_SEED : seed;
        if (start) begin
          used_nxt  = '0;
          count_nxt = '0;
          state_nxt = PICK;
        end
      end
      PICK: begin
        lfsr_nxt  = lfsr_adv;
        idx_nxt   = idx_raw;
        state_nxt = PROBE;
      end
      PROBE: begin
        if (!used[idx]) begin
          used_nxt[idx] = 1'b1;
          rank_nxt      = rank_of_idx;
          suit_nxt      = suit_of_idx;
          player_nxt    = count[0];
          slot_nxt      = count[3:1];
          state_nxt     = PRESENT;
        end else begin
          idx_nxt = (idx == DECK_LAST) ? 6'd0 : idx + 6'd1;
        end
      end
      PRESENT: begin
        if (cards.card_ready) begin
          count_nxt = count + 4'd1;
          state_nxt = (count == LAST_CARD) ? DONE : PICK;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      lfsr   <= LFSR_SEED;
      used   <= '0;
      count  <= '0;
      idx    <= '0;
      rank   <= '0;
      suit   <= '0;
      player <= 1'b0;
      slot   <= '0;
    end else begin
      state  <= state_nxt;
      lfsr   <= lfsr_nxt;
      used   <= used_nxt;
      count  <= count_nxt;
      idx    <= idx_nxt;
      rank   <= rank_nxt;
      suit   <= suit_nxt;
      player <= player_nxt;
      slot   <= slot_nxt;
    end
  end

  assign cards.card_valid  = (state == PRESENT);
  assign cards.card_rank   = rank;
  assign cards.card_suit   = suit;
  assign cards.card_player = player;
  assign cards.card_slot   = slot;
  assign busy              = (state != IDLE);
  assign done              = (state == DONE);

endmodule
